// File: rtl/vs_pkg.sv
// vs_pkg: command/reply bytes, state encoding and byte-count helper for vector_sequencer
package vs_pkg;
  localparam logic [7:0] CMD_VEC = 8'h56;
  localparam logic [7:0] CMD_RST = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_BAD = 8'h3F;
  localparam logic [7:0] RSP_TMO = 8'h21;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_APPLY   = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_SEND    = 3'd5;
  localparam logic [2:0] S_WAIT_LO = 3'd6;
  localparam logic [2:0] S_WAIT_HI = 3'd7;
  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction
endpackage

// File: rtl/vs_byte_tx.sv
// vs_byte_tx: serializes the top cnt bytes of word (MSB byte first) onto the tx_start/tx_ready handshake
module vs_byte_tx import vs_pkg::*; #(
  parameter int NB = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      cnt,
  input  logic [NB*8-1:0] word,
  input  logic            tx_ready,
  output logic [7:0]      tx_data,
  output logic            tx_start,
  output logic            done
);
  logic [2:0] st, left;
  logic [NB*8-1:0] sh;
  assign done = st == S_WAIT_HI && tx_ready && left == 3'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_IDLE;
      sh       <= '0;
      left     <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (st)
        S_IDLE: if (start) begin
          sh   <= word;
          left <= cnt;
          st   <= S_SEND;
        end
        S_SEND: if (tx_ready) begin
          tx_start <= 1'b1;
          tx_data  <= sh[NB*8-1 -: 8];
          sh       <= sh << 8;
          left     <= left - 3'd1;
          st       <= S_WAIT_LO;
        end
        S_WAIT_LO: if (!tx_ready) st <= S_WAIT_HI;
        S_WAIT_HI: if (tx_ready) st <= left == 3'd0 ? S_IDLE : S_SEND;
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/vector_sequencer.sv
// vector_sequencer: byte-command controller that applies UART-assembled vectors to part_pis and returns part_pos
module vector_sequencer import vs_pkg::*; #(
  parameter int NPIS    = 14,
  parameter int NPOS    = 11,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_ready,
  output logic [1:NPIS] part_pis,
  input  logic [1:NPOS] part_pos,
  output logic          busy,
  output logic [15:0]   vec_count,
  output logic          overrun
);
  localparam int NI = nbytes(NPIS);
  localparam int NO = nbytes(NPOS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [2:0]    NI_LAST = 3'(NI - 1);
  localparam logic [2:0]    NO_CNT  = 3'(NO);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SE_LAST = SW'(SETTLE - 1);
  logic [2:0] st, bcnt;
  logic [NPIS-1:0] assy;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic [NO*8-1:0] pos_ext, word;
  logic [7:0] reply;
  logic tx_go, tx_done, timeout;
  assign busy = st != S_IDLE;
  // one serializer carries both captured vectors and single-byte replies
  always_comb begin
    timeout = st == S_COLLECT && !rx_valid && tcnt == TO_LAST;
    reply = st == S_COLLECT ? RSP_TMO : rx_data == CMD_RST ? RSP_OK : RSP_BAD;
    tx_go = st == S_CAPTURE || timeout || (st == S_IDLE && rx_valid && rx_data != CMD_VEC);
    pos_ext = '0;
    pos_ext[NPOS-1:0] = part_pos;
    word = '0;
    word[NO*8-1 -: 8] = reply;
    if (st == S_CAPTURE) word = pos_ext;
  end
  vs_byte_tx #(.NB(NO)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (tx_go),
    .cnt      (st == S_CAPTURE ? NO_CNT : 3'd1),
    .word     (word),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .done     (tx_done)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      assy      <= '0;
      bcnt      <= '0;
      tcnt      <= '0;
      scnt      <= '0;
      part_pis  <= '0;
      vec_count <= '0;
      overrun   <= 1'b0;
    end else begin
      if (rx_valid && st != S_IDLE && st != S_COLLECT) overrun <= 1'b1;
      case (st)
        S_IDLE: if (rx_valid) begin
          if (rx_data == CMD_VEC) begin
            st   <= S_COLLECT;
            bcnt <= '0;
            tcnt <= '0;
          end else begin
            st <= S_SEND;
            if (rx_data == CMD_RST) begin
              part_pis  <= '0;
              vec_count <= '0;
              overrun   <= 1'b0;
            end
          end
        end
        S_COLLECT: if (rx_valid) begin
          assy <= NPIS'({assy, rx_data});
          bcnt <= bcnt + 3'd1;
          tcnt <= '0;
          if (bcnt == NI_LAST) st <= S_APPLY;
        end else if (timeout) st <= S_SEND;
        else tcnt <= tcnt + 1'b1;
        S_APPLY: begin
          part_pis <= assy;
          scnt     <= '0;
          st       <= S_SETTLE;
        end
        S_SETTLE: if (scnt == SE_LAST) st <= S_CAPTURE;
        else scnt <= scnt + 1'b1;
        S_CAPTURE: begin
          vec_count <= vec_count + 16'd1;
          st        <= S_SEND;
        end
        S_SEND: if (tx_done) st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_sequencer.sv
// tb_vector_sequencer: table-driven vectors plus hand-written reset/timeout/overrun/backpressure sequences
module tb_vector_sequencer;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0, tx_data;
  logic rx_valid = 0, tx_start, tx_ready, busy, overrun;
  logic [13:0] part_pis;
  logic [10:0] part_pos = 0;
  logic [15:0] vec_count;
  int total = 0, bad = 0, cyc = 0, last_rise = 0, mcnt = 0, viol = 0;
  logic hold = 0;
  logic [7:0] txq[$];
  int gaps[$];
  typedef struct { logic [7:0] b1, b2; logic [10:0] pos; logic [13:0] pis; logic [7:0] o0, o1; } row_t;
  row_t rows[4];

  vector_sequencer #(.NPIS(14), .NPOS(11), .SETTLE(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .part_pis(part_pis), .part_pos(part_pos), .busy(busy),
    .vec_count(vec_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // transmitter model: goes busy for 3 cycles after each tx_start, optionally held off by hold
  initial begin
    tx_ready = 1;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_start) begin
        if (!tx_ready) viol++;
        txq.push_back(tx_data);
        gaps.push_back(cyc - last_rise);
      end
      if (rst) mcnt = 0;
      else if (tx_start) mcnt = 3;
      else if (mcnt > 0) mcnt--;
      if (!hold && mcnt == 0 && !tx_ready) last_rise = cyc;
      tx_ready = !hold && mcnt == 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 500 && txq.size() < n; i++) @(negedge clk);
    chk("tx_wait", txq.size() >= n, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && busy; i++) @(negedge clk);
    chk("idle", busy, 0);
  endtask

  initial begin
    int base, n, p;
    logic [13:0] prev_pis;
    rows[0] = '{8'h2A, 8'h5C, 11'h5A3, 14'h2A5C, 8'h05, 8'hA3};
    rows[1] = '{8'hFF, 8'hFF, 11'h000, 14'h3FFF, 8'h00, 8'h00};
    rows[2] = '{8'h80, 8'h01, 11'h7FF, 14'h0001, 8'h07, 8'hFF};
    rows[3] = '{8'hC3, 8'h3C, 11'h400, 14'h033C, 8'h04, 8'h00};
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_outs", {tx_start, tx_data, part_pis, busy, vec_count, overrun}, 0);
    prev_pis = 0;
    // vectors: part_pos only holds the expected value on the single sampling cycle
    for (int i = 0; i < 4; i++) begin
      base = txq.size();
      send(8'h56);
      send(rows[i].b1);
      part_pos = rows[i].pos ^ 11'h7FF;
      send(rows[i].b2);
      chk("pis_hold", part_pis, prev_pis);
      @(negedge clk);
      chk("pis_apply", part_pis, rows[i].pis);
      chk("busy", busy, 1);
      repeat (4) @(negedge clk);
      part_pos = rows[i].pos;
      @(negedge clk);
      part_pos = rows[i].pos ^ 11'h7FF;
      chk("vec_count", vec_count, i + 1);
      wait_tx(base + 2);
      chk("tx_b0", txq[base], rows[i].o0);
      chk("tx_b1", txq[base + 1], rows[i].o1);
      wait_idle();
      prev_pis = rows[i].pis;
    end
    // 'R' command
    base = txq.size();
    send(8'h52);
    wait_tx(base + 1);
    chk("rst_cmd_reply", txq[base], 8'h4B);
    chk("rst_cmd_pis", part_pis, 0);
    chk("rst_cmd_cnt", vec_count, 0);
    wait_idle();
    // timeout
    base = txq.size();
    send(8'h56);
    send(8'h12);
    n = 0;
    while (n < 300 && txq.size() <= base) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_window", n >= 100 && n <= 103, 1);
    chk("tmo_reply", txq[base], 8'h21);
    wait_idle();
    chk("tmo_pis", part_pis, 0);
    chk("no_overrun", overrun, 0);
    // unknown command, then overrun during SETTLE
    base = txq.size();
    send(8'h41);
    wait_tx(base + 1);
    chk("unk_reply", txq[base], 8'h3F);
    wait_idle();
    base = txq.size();
    part_pos = 11'h3C5;
    send(8'h56);
    send(8'h01);
    send(8'h23);
    send(8'h77);
    chk("overrun", overrun, 1);
    wait_tx(base + 2);
    chk("ovr_b0", txq[base], 8'h03);
    chk("ovr_b1", txq[base + 1], 8'hC5);
    chk("ovr_pis", part_pis, 14'h0123);
    chk("ovr_cnt", vec_count, 1);
    wait_idle();
    // transmit backpressure
    @(negedge clk);
    hold = 1;
    base = txq.size();
    part_pos = 11'h7E1;
    send(8'h56);
    send(8'hAB);
    send(8'hCD);
    repeat (60) @(negedge clk);
    chk("bp_no_start", txq.size(), base);
    chk("bp_busy", busy, 1);
    #1 hold = 0;
    wait_tx(base + 2);
    chk("bp_gap", gaps[base], 1);
    chk("bp_b0", txq[base], 8'h07);
    chk("bp_b1", txq[base + 1], 8'hE1);
    chk("bp_pis", part_pis, 14'h2BCD);
    repeat (20) @(negedge clk);
    chk("bp_count", txq.size(), base + 2);
    // asynchronous reset right after the second response byte starts
    base = txq.size();
    part_pos = 11'h456;
    send(8'h56);
    send(8'h11);
    send(8'h22);
    p = 0;
    for (int i = 0; i < 300 && p < 2; i++) begin
      @(posedge clk);
      #1;
      if (tx_start) p++;
    end
    chk("mid_pulses", p, 2);
    rst = 1;
    #1;
    chk("mid_rst_outs", {tx_start, tx_data, part_pis, busy, vec_count, overrun}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("mid_no_more_tx", txq.size(), base + 1);
    chk("mid_first_byte", txq[base], 8'h04);
    base = txq.size();
    part_pos = 11'h001;
    send(8'h56);
    send(8'h00);
    send(8'h07);
    wait_tx(base + 2);
    chk("post_b0", txq[base], 8'h00);
    chk("post_b1", txq[base + 1], 8'h01);
    chk("post_pis", part_pis, 14'h0007);
    chk("post_cnt", vec_count, 1);
    wait_idle();
    chk("tx_while_busy", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
Byte-command controller that sequences the part-under-test pins from the UART byte stream. It assembles an NPIS-bit input vector from received bytes and drives it onto part_pis. After a programmable settle time it captures part_pos and returns the captured bits as bytes through the UART transmitter handshake. It sits between uart_rx/uart_tx and the part pins, in place of the free-form command parser on the test board.

Parameters:
NPIS, 14, width of the part primary-input vector (1..32)
NPOS, 11, width of the part primary-output vector (1..32)
SETTLE, 4, clock cycles between applying part_pis and sampling part_pos (>=1)
TIMEOUT, 1000000, idle clock cycles allowed between payload bytes before the vector is aborted

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle transmit request
tx_ready  in  1  transmitter idle
part_pis  out  [1:NPIS]  drive to the part; part_pis[1] is the MSB
part_pos  in  [1:NPOS]  part outputs; part_pos[1] is the MSB
busy  out  1  high in every state except IDLE
vec_count  out  16  number of completed captures
overrun  out  1  sticky; a byte arrived while it could not be accepted

Behaviour:
- Reset: all outputs are 0, the state is IDLE, and the assembly register is 0. Reset applies asynchronously, including mid-vector and mid-transmit. No partial byte is completed after reset.
- Byte counts: NI=ceil(NPIS/8) and NO=ceil(NPOS/8).
- Commands, accepted in IDLE only:
  - 'V' (0x56): go to COLLECT.
  - 'R' (0x52): set part_pis=0, vec_count=0 and overrun=0, then reply 'K' (0x4B).
  - Any other byte: reply '?' (0x3F). No other state changes.
- States: IDLE, COLLECT, APPLY, SETTLE, CAPTURE, SEND, WAIT_LO, WAIT_HI.
- COLLECT:
  - Each rx_valid shifts rx_data into the assembly register, MSB-first: assy <= {assy[..], rx_data}.
  - The byte counter increments on each byte. The timeout counter clears on each byte.
  - When NI bytes are collected, go to APPLY.
  - If TIMEOUT cycles pass with no byte, reply '!' (0x21) and return to IDLE. part_pis is unchanged.
- APPLY (1 cycle): part_pis <= the low NPIS bits of assy. Upper bits are discarded. The state then moves to SETTLE.
- SETTLE: count SETTLE cycles, then go to CAPTURE.
- CAPTURE (1 cycle):
  - Latch part_pos, zero-extended to NO*8 bits.
  - vec_count increments, wrapping from 0xFFFF to 0.
  - Go to SEND with the byte index at 0.
- Latency: if the last payload byte is strobed at cycle t, part_pis changes at t+2 and part_pos is sampled at t+2+SETTLE.
- Transmit handshake:
  - In SEND, when tx_ready=1, assert tx_start for exactly one cycle with tx_data held valid in that cycle.
  - WAIT_LO: wait for tx_ready=0.
  - WAIT_HI: wait for tx_ready=1, then send the next byte (MSB byte first) or return to IDLE after the last one.
  - tx_data holds its value until the next tx_start.
  - Single-byte replies ('K', '?', '!') use the same SEND/WAIT path with a byte count of 1.
- Boundary cases:
  - rx_valid in APPLY, SETTLE, CAPTURE, SEND, WAIT_LO or WAIT_HI: the byte is dropped and overrun is set.
  - rx_valid on the same cycle as a COLLECT timeout: the byte is accepted and the timeout is cancelled.
  - If tx_ready is already 0 on entry to SEND, wait. Never pulse tx_start while tx_ready=0.
  - part_pis changes only in APPLY or on 'R'. It holds its last value at all other times.

Decomposition:
- Package vs_pkg: the command and reply byte constants (0x56, 0x52, 0x4B, 0x3F, 0x21), the state encoding, and the NI/NO byte-count functions.
- One sub-module, vs_byte_tx: a byte serializer from a NO*8-bit word onto the tx_start/tx_ready handshake. It has a start/count input and a done pulse, and holds the SEND, WAIT_LO and WAIT_HI states.

Test Plan:
All scenarios use NPIS=14, NPOS=11, SETTLE=4.
1. Apply and capture: send 0x56, 0x2A, 0x5C with the bench forcing part_pos=11'h5A3. Expect part_pis=14'h2A5C two cycles after the last strobe, part_pos sampled 4 cycles later, tx bytes 0x05 then 0xA3, and vec_count=1.
2. Truncation and reset command: send 0x56, 0xFF, 0xFF. Expect part_pis=14'h3FFF. Then send 0x52. Expect part_pis=0, vec_count=0, and reply 0x4B.
3. Timeout: with TIMEOUT=100, send 0x56, 0x12 and then nothing for 100 cycles. Expect reply 0x21, return to IDLE, and part_pis unchanged.
4. Unknown command and overrun: send 0x41 in IDLE. Expect reply 0x3F. Then inject a byte during SETTLE. Expect overrun=1 and no effect on the captured vector.
5. Transmit backpressure: hold tx_ready=0 for 50 cycles at SEND entry. Expect tx_start to stay 0 and the first pulse to come exactly 1 cycle after tx_ready rises. Exactly NO pulses in total.
6. Reset mid-operation: assert rst during WAIT_LO of the second response byte. Expect all outputs 0 immediately and no further tx_start. The next 0x56 sequence operates normally.
